// File: rtl/lc3b_types.sv
// Shared LC-3b types for the cache controller: FSM state encoding, way
// identifiers and the victim-selection helper used on a read miss.
package lc3b_types;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } cache_ctrl_state_t;

  typedef enum logic {
    WAY_ONE = 1'b0,
    WAY_TWO = 1'b1
  } lc3b_way_t;

  // An invalid way is always preferred over evicting live data; with both
  // ways valid the least recently used one is replaced.
  function automatic lc3b_way_t pick_victim(input logic one_valid,
                                            input logic two_valid,
                                            input logic lru);
    lc3b_way_t way_v;
    if (!one_valid) begin
      way_v = WAY_ONE;
    end else if (!two_valid) begin
      way_v = WAY_TWO;
    end else begin
      way_v = lc3b_way_t'(lru);
    end
    return way_v;
  endfunction

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
module cache_perf_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  // Count register: increments on each event until it saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= CNT_ZERO;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way set-associative, read-only LC-3b cache.
// Hits are answered in the CHECK cycle; misses fetch a line from pmem into
// the chosen victim way, bubble once in FILL, then retry the lookup.
// Optional hit/miss performance counters are built when CACHE_PERF_CNT_EN
// is defined; otherwise hit_count/miss_count are constant zero.
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  output logic                 mem_resp,
  input  logic                 hit,
  input  logic                 set_one_hit,
  input  logic                 set_two_hit,
  input  logic                 set_one_valid,
  input  logic                 set_two_valid,
  input  logic                 current_lru,
  output logic                 load_set_one,
  output logic                 load_set_two,
  output logic                 load_lru,
  output logic                 pmem_read,
  input  logic                 pmem_resp,
  output logic                 pmem_err,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1'b1);

  cache_ctrl_state_t state_r, state_s;
  lc3b_way_t         victim_r, victim_s;
  logic [TO_W-1:0]   to_cnt_r;
  logic              pmem_err_r;

  // State and latched victim way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= CHECK;
      victim_r <= WAY_ONE;
    end else begin
      state_r  <= state_s;
      victim_r <= victim_s;
    end
  end

  // Next state and strobes; outputs are forced low while reset is held so
  // nothing leaks out combinationally from mem_read/hit during reset.
  always_comb begin
    state_s      = state_r;
    victim_s     = victim_r;
    mem_resp     = 1'b0;
    load_lru     = 1'b0;
    load_set_one = 1'b0;
    load_set_two = 1'b0;
    pmem_read    = 1'b0;
    if (!reset_n) begin
      state_s = CHECK;
    end else begin
      case (state_r)
        CHECK: begin
          if (mem_read && hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
          end else if (mem_read) begin
            victim_s = pick_victim(set_one_valid, set_two_valid, current_lru);
            state_s  = FETCH;
          end else begin
            state_s = CHECK;
          end
        end
        FETCH: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_set_one = (victim_r == WAY_ONE);
            load_set_two = (victim_r == WAY_TWO);
            state_s      = FILL;
          end else begin
            state_s = FETCH;
          end
        end
        FILL: begin
          state_s = CHECK;
        end
        default: begin
          state_s = CHECK;
        end
      endcase
    end
  end

  // Fetch watchdog: counts FETCH cycles with no pmem_resp; the error flag is
  // sticky until reset and does not abort the fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r   <= TO_ZERO;
      pmem_err_r <= 1'b0;
    end else if ((state_r == CHECK) && (state_s == FETCH)) begin
      to_cnt_r   <= TO_ZERO;
      pmem_err_r <= pmem_err_r;
    end else if ((state_r == FETCH) && !pmem_resp) begin
      if (to_cnt_r != TO_MAX) begin
        to_cnt_r <= to_cnt_r + TO_ONE;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
      if (to_cnt_r == TO_LAST) begin
        pmem_err_r <= 1'b1;
      end else begin
        pmem_err_r <= pmem_err_r;
      end
    end else begin
      to_cnt_r   <= to_cnt_r;
      pmem_err_r <= pmem_err_r;
    end
  end

  assign pmem_err = pmem_err_r;

`ifdef CACHE_PERF_CNT_EN
  logic retry_r;
  logic hit_inc_s;
  logic miss_inc_s;

  // Marks the CHECK cycle right after FILL so the retry hit is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_r <= 1'b0;
    end else begin
      retry_r <= (state_r == FILL);
    end
  end

  assign hit_inc_s  = reset_n && (state_r == CHECK) && mem_read && hit && !retry_r;
  assign miss_inc_s = reset_n && (state_r == CHECK) && (state_s == FETCH);

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hit_inc_s),
    .count   (hit_count)
  );

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (miss_inc_s),
    .count   (miss_count)
  );
`else
  assign hit_count  = {CNT_WIDTH{1'b0}};
  assign miss_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control with a one-set datapath model and a
// scoreboard of expected per-request results.
module tb_cache_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_read = 1'b0;
  logic       mem_resp;
  logic       hit = 1'b0;
  logic       set_one_hit = 1'b0;
  logic       set_two_hit = 1'b0;
  logic       set_one_valid = 1'b0;
  logic       set_two_valid = 1'b0;
  logic       current_lru = 1'b0;
  logic       load_set_one;
  logic       load_set_two;
  logic       load_lru;
  logic       pmem_read;
  logic       pmem_resp = 1'b0;
  logic       pmem_err;
  logic [1:0] hit_count;
  logic [1:0] miss_count;

  int n_assert = 0;
  int n_fail   = 0;

  // One-set datapath model: tags, valid bits and LRU.
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] tg0 = 8'h00, tg1 = 8'h00;
  logic       lru_m = 1'b0;

  typedef struct {
    string      tag;
    int         lat;
    logic [1:0] lds;
    int         pm;
    int         errf;
  } exp_t;
  exp_t sb_q[$];

  cache_control #(.CNT_WIDTH(2), .TIMEOUT(4)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_read      (mem_read),
    .mem_resp      (mem_resp),
    .hit           (hit),
    .set_one_hit   (set_one_hit),
    .set_two_hit   (set_two_hit),
    .set_one_valid (set_one_valid),
    .set_two_valid (set_two_valid),
    .current_lru   (current_lru),
    .load_set_one  (load_set_one),
    .load_set_two  (load_set_two),
    .load_lru      (load_lru),
    .pmem_read     (pmem_read),
    .pmem_resp     (pmem_resp),
    .pmem_err      (pmem_err),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef CACHE_PERF_CNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return (n > 3) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic drive_dp(input logic [7:0] t);
    set_one_hit   = v0 && (tg0 == t);
    set_two_hit   = v1 && (tg1 == t);
    hit           = set_one_hit || set_two_hit;
    set_one_valid = v0;
    set_two_valid = v1;
    current_lru   = lru_m;
  endtask

  task automatic push_exp(input string tag, input int lat, input logic [1:0] lds,
                          input int pm, input int errf);
    exp_t e;
    e.tag = tag; e.lat = lat; e.lds = lds; e.pm = pm; e.errf = errf;
    sb_q.push_back(e);
  endtask

  // Runs one CPU read; entered and left just after a rising edge.
  task automatic run_read(input logic [7:0] t, input int lat_req);
    exp_t       e;
    int         cyc = 0, fidx = 0, pm = 0, errf = 0;
    logic [1:0] lds = 2'b00;
    bit         done = 1'b0;
    mem_read = 1'b1;
    while (!done && cyc < 40) begin
      cyc++;
      drive_dp(t);
      if (pmem_read) fidx++;
      pmem_resp = pmem_read && (fidx == lat_req);
      @(negedge clk);
      pm += int'(pmem_read);
      if (pmem_read && pmem_err && errf == 0) errf = fidx;
      lds |= {load_set_two, load_set_one};
      check("inv_one_load", 32'(load_set_one && load_set_two), 32'd0);
      check("inv_lru_eq_resp", 32'(load_lru), 32'(mem_resp));
      if (load_set_one) begin v0 = 1'b1; tg0 = t; end
      if (load_set_two) begin v1 = 1'b1; tg1 = t; end
      if (load_lru) lru_m = set_one_hit ? 1'b1 : 1'b0;
      if (mem_resp) done = 1'b1;
      @(posedge clk); #1;
    end
    mem_read  = 1'b0;
    pmem_resp = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_resp_seen"}, 32'(done), 32'd1);
      check({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({e.tag, "_loads"}, 32'(lds), 32'(e.lds));
      check({e.tag, "_pmem_cycles"}, 32'(pm), 32'(e.pm));
      check({e.tag, "_err_first"}, 32'(errf), 32'(e.errf));
    end
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_mem_resp", 32'(mem_resp), 32'd0);
    check("rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_loads", 32'({load_set_one, load_set_two, load_lru}), 32'd0);
    check("rst_pmem_err", 32'(pmem_err), 32'd0);
    check("rst_counts", 32'({hit_count, miss_count}), 32'd0);
    #20;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: cold miss, 5-cycle pmem; watchdog (4) trips during the fetch
    push_exp("t1_cold", 8, 2'b01, 5, 5);
    run_read(8'hA0, 5);
    check("t1_miss_count", 32'(miss_count), exp_cnt(1));
    check("t1_hit_count", 32'(hit_count), exp_cnt(0));
    check("t1_err_sticky", 32'(pmem_err), 32'd1);

    // 2: repeat read hits in one cycle
    push_exp("t2_hit", 1, 2'b00, 0, 0);
    run_read(8'hA0, 5);
    check("t2_hit_count", 32'(hit_count), exp_cnt(1));

    // 3: way two invalid, then LRU-driven replacements
    push_exp("t3_fill_two", 5, 2'b10, 2, 1);
    run_read(8'hB0, 2);
    push_exp("t3_hit_a", 1, 2'b00, 0, 0);
    run_read(8'hA0, 2);
    push_exp("t3_lru1", 6, 2'b10, 3, 1);
    run_read(8'hC0, 3);
    push_exp("t3_lru0", 6, 2'b01, 3, 1);
    run_read(8'hD0, 3);
    check("t3_hit_count", 32'(hit_count), exp_cnt(2));
    check("t3_miss_count", 32'(miss_count), exp_cnt(4));

    // 4: async reset in the middle of a fetch
    mem_read = 1'b1;
    drive_dp(8'hE0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_fetching", 32'(pmem_read), 32'd1);
    #2;
    reset_n  = 1'b0;
    #1;
    check("t4_async_pmem_read", 32'(pmem_read), 32'd0);
    check("t4_rst_err", 32'(pmem_err), 32'd0);
    check("t4_rst_counts", 32'({hit_count, miss_count}), 32'd0);
    mem_read = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_late_resp_loads", 32'({load_set_one, load_set_two}), 32'd0);
      check("t4_late_resp_pmem_read", 32'(pmem_read), 32'd0);
      check("t4_late_resp_mem_resp", 32'(mem_resp), 32'd0);
      @(posedge clk); #1;
    end
    pmem_resp = 1'b0;

    // 5: pmem withheld 10 cycles; error rises after 4 FETCH cycles
    check("t5_err_before", 32'(pmem_err), 32'd0);
    push_exp("t5_timeout", 14, 2'b10, 11, 5);
    run_read(8'hF0, 11);
    check("t5_err_after", 32'(pmem_err), 32'd1);

    // 6: five hits saturate the 2-bit hit counter
    for (int i = 0; i < 5; i++) begin
      push_exp("t6_hit", 1, 2'b00, 0, 0);
      run_read(8'hF0, 1);
    end
    check("t6_hit_sat", 32'(hit_count), exp_cnt(5));
    check("t6_miss_count", 32'(miss_count), exp_cnt(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
